// File: rtl/muldiv.sv
// RV32M multiply/divide unit with a fixed 32-iteration latency.
// An accepted operation runs 32 CALC cycles (one partial product or quotient
// bit per cycle), then spends one DONE cycle presenting the register-file write.
//
// Ports:
//   clk    in   clock, all state updates on rising edge
//   rst    in   synchronous active-high reset
//   start  in   request a new operation (sampled only while busy=0)
//   op     in   [2:0] RV32M funct3
//   a, b   in   [31:0] operands
//   rd     in   [4:0] destination register
//   busy   out  operation in flight (CALC or DONE)
//   we     out  register-file write strobe (DONE only, suppressed for rd=0)
//   wa     out  [4:0] write address
//   wd     out  [31:0] write data
module muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] opnd_q;   // multiplicand or divisor magnitude
  logic [63:0] acc_q;    // mul: {product hi, multiplier/product lo}; div: {remainder, quotient}
  logic        nq_q;     // negate product / quotient at the end
  logic        nr_q;     // negate remainder at the end

  // Operand capture: signed operands are turned into magnitudes up front.
  logic        sa, sb;
  logic [31:0] ma, mb;

  always_comb begin
    sa = a[31] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    sb = b[31] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
    ma = sa ? -a : a;
    mb = sb ? -b : b;
  end

  // One iteration of the shared datapath, plus the result it would finish with.
  logic [32:0] msum;
  logic [32:0] dtrial;
  logic [63:0] acc_d;
  logic [63:0] prod;
  logic [31:0] quo, rem;
  logic [31:0] result;

  always_comb begin
    msum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Shifted partial remainder {rem, next dividend bit} minus divisor;
    // bit 32 set means the trial went negative and must be restored.
    dtrial = acc_q[63:31] - {1'b0, opnd_q};
    if (op_q[2]) begin
      acc_d = dtrial[32] ? {acc_q[62:0], 1'b0} : {dtrial[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_d = {msum, acc_q[31:1]};
    end
    prod = nq_q ? -acc_d : acc_d;
    quo  = nq_q ? -acc_d[31:0] : acc_d[31:0];
    rem  = nr_q ? -acc_d[63:32] : acc_d[63:32];
    unique case (op_q)
      3'b000:                 result = prod[31:0];
      3'b001, 3'b010, 3'b011: result = prod[63:32];
      3'b100, 3'b101:         result = quo;
      default:                result = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      opnd_q  <= 32'd0;
      acc_q   <= 64'd0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      busy    <= 1'b0;
      we      <= 1'b0;
      wa      <= 5'd0;
      wd      <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StCalc;
            busy    <= 1'b1;
            cnt_q   <= 5'd0;
            op_q    <= op;
            rd_q    <= rd;
            nr_q    <= sa;
            if (op[2]) begin
              acc_q  <= {32'd0, ma};
              opnd_q <= mb;
              // Divide by zero keeps the all-ones quotient unsigned.
              nq_q   <= (sa ^ sb) & (b != 32'd0);
            end else begin
              acc_q  <= {32'd0, mb};
              opnd_q <= ma;
              nq_q   <= sa ^ sb;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= StDone;
            we      <= (rd_q != 5'd0);
            wa      <= rd_q;
            wd      <= result;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          we      <= 1'b0;
          wa      <= 5'd0;
          wd      <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        busy, we;
  logic [4:0]  wa;
  logic [31:0] wd;

  int n_checks = 0;
  int n_pass   = 0;

  logic [36:0] sb_q[$];  // {wa, wd} expected per write pulse

  muldiv dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .rd    (rd),
    .busy  (busy),
    .we    (we),
    .wa    (wa),
    .wd    (wd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (o)
      3'd0: begin p = 64'(ux * uy); return p[31:0];  end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = 64'(ux * uy); return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sx / sy); return p[31:0];
      end
      3'd5: begin if (y == 0) return 32'hFFFF_FFFF; return x / y; end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sx % sy); return p[31:0];
      end
      default: begin if (y == 0) return x; return x % y; end
    endcase
  endfunction

  // Every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (we) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_we", {59'd0, wa}, 64'hdead);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check_eq("wa", {59'd0, wa}, {59'd0, e[36:32]});
        check_eq("wd", {32'd0, wd}, {32'd0, e[31:0]});
      end
    end
  end

  // mode 0: normal, 1: re-pulse start mid-CALC, 2: reset at iteration 10.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input logic [31:0] exp, input int mode);
    int we_at, we_cnt, fall_at;
    logic b0, leak;
    we_at = -1; we_cnt = 0; fall_at = -1; b0 = 1'b0; leak = 1'b0;
    @(negedge clk);
    op = o; a = x; b = y; rd = r; start = 1'b1;
    if (r != 0 && mode != 2) sb_q.push_back({r, exp});
    @(posedge clk);  // edge k
    #1 start = 1'b0;
    a = ~x; b = ~y; op = ~o; rd = ~r;  // later input changes must not matter
    for (int j = 0; j <= 33; j++) begin
      @(negedge clk);  // sampled after edge k+j
      if (j == 0) b0 = busy;
      if (we) begin we_cnt++; if (we_at < 0) we_at = j; end
      if (!busy && fall_at < 0) fall_at = j;
      if (j < 32 && (we || wa != 0 || wd != 0)) leak = 1'b1;
      if (mode == 1 && j == 5) begin
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; rd = 5'd9;
      end
      if (mode == 1 && j == 6) start = 1'b0;
      if (mode == 2 && j == 10) rst = 1'b1;
      if (mode == 2 && j == 11) begin
        rst = 1'b0;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_we", {63'd0, we}, 64'd0);
        repeat (40) @(negedge clk);  // monitor flags any late write
        return;
      end
    end
    check_eq("busy_at_k", {63'd0, b0}, 64'd1);
    check_eq("we_edge", 64'(we_at), (r != 0) ? 64'd32 : 64'(-1));
    check_eq("we_count", 64'(we_cnt), (r != 0) ? 64'd1 : 64'd0);
    check_eq("busy_fall", 64'(fall_at), 64'd33);
    check_eq("calc_outputs_zero", {63'd0, leak}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; rd = 5'd0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;  // rst must win over start
    @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_outs", {26'd0, we, wa, wd}, 64'd0);
    rst = 1'b0; start = 1'b0;

    run_op(3'd0, 32'd7, 32'd6, 5'd3, 32'd42, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd13, 32'd2, 0);
    run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd15, 32'd1, 0);
    run_op(3'd4, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'd5, 32'd0, 5'd17, 32'd5, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd18, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd19, 32'hFFFF_FFF9, 0);
    run_op(3'd5, 32'd5, 32'd0, 5'd20, 32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'h8000_0003, 32'd0, 5'd21, 32'h8000_0003, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'd0, 0);
    run_op(3'd0, 32'd7, 32'd6, 5'd24, 32'd42, 1);   // start re-pulsed mid-CALC
    run_op(3'd0, 32'd7, 32'd6, 5'd0, 32'd42, 0);    // rd=0: no write
    run_op(3'd5, 32'd100, 32'd7, 5'd25, 32'd14, 2); // aborted by reset
    run_op(3'd5, 32'd100, 32'd7, 5'd25, 32'd14, 0);

    for (int i = 0; i < 16; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 5 == 4) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(ro, ra, rb, 5'($urandom_range(1, 31)), ref_model(ro, ra, rb), 0);
    end

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
